coherence_bus_ctrl: RTL and testbench

- Central MESI coherence controller shared by two private L1 data caches.
- Arbitrates read/write miss requests round-robin, snoops the non-requesting cache, and writes back dirty snooped data to memory.
- Sources the requested word by cache-to-cache transfer or memory read, then returns data plus the MESI end state to the requester.
- Sits between the L1 caches and the single memory/bus port.

---
 rtl/coherence_bus_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_coherence_bus_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/coherence_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : coherence_bus_ctrl
//  Purpose  : MESI coherence controller shared by two private L1 data caches.
//             Grants miss requests round-robin, snoops the other cache, writes
//             dirty snooped data back to memory, then returns the word and the
//             requester's MESI end state.
//  Ports    : CLK/nRST              clock, synchronous active-low reset
//             req_valid/req_write   per-cache miss request and RFO flag
//             req_addr0/req_addr1   per-cache miss address
//             done/resp_data/resp_state  completion pulse, word, end state
//             snoop_req/snoop_inv/snoop_addr  snoop strobe to the other cache
//             snoop_hit/snoop_dirty/snoop_data0/1  snoop response
//             mem_ren/mem_wen/mem_addr/mem_wdata/mem_rdata/mem_busy  memory
//  Revision : 1.0  initial release
// ============================================================================
module coherence_bus_ctrl #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [1:0]        req_valid,
  input  logic [1:0]        req_write,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  output logic [1:0]        done,
  output logic [WORD_W-1:0] resp_data,
  output logic [1:0]        resp_state,
  output logic [1:0]        snoop_req,
  output logic [1:0]        snoop_inv,
  output logic [ADDR_W-1:0] snoop_addr,
  input  logic [1:0]        snoop_hit,
  input  logic [1:0]        snoop_dirty,
  input  logic [WORD_W-1:0] snoop_data0,
  input  logic [WORD_W-1:0] snoop_data1,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SNOOP = 3'd1,
    S_WB    = 3'd2,
    S_MEMRD = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  localparam logic [1:0] c_MODIFIED  = 2'd0;
  localparam logic [1:0] c_EXCLUSIVE = 2'd1;
  localparam logic [1:0] c_SHARED    = 2'd2;

  state_t            r_state;
  logic              r_gnt;
  logic              r_last_grant;
  logic              r_write;
  logic              r_hit;
  logic [ADDR_W-1:0] r_addr;
  logic [WORD_W-1:0] r_data;

  logic              w_any_req;
  logic              w_gnt;
  logic [1:0]        w_other_mask;
  logic [ADDR_W-1:0] w_req_addr;
  logic              w_other_hit;
  logic              w_other_dirty;
  logic [WORD_W-1:0] w_other_data;

  // Round-robin: on a tie the cache that did not win last time is granted.
  assign w_any_req    = |req_valid;
  assign w_gnt        = (&req_valid) ? ~r_last_grant : req_valid[1];
  assign w_other_mask = w_gnt ? 2'b01 : 2'b10;
  assign w_req_addr   = w_gnt ? req_addr1 : req_addr0;

  // Snoop response always comes from the cache that was not granted.
  assign w_other_hit   = r_gnt ? snoop_hit[0]   : snoop_hit[1];
  assign w_other_dirty = r_gnt ? snoop_dirty[0] : snoop_dirty[1];
  assign w_other_data  = r_gnt ? snoop_data0    : snoop_data1;

  function automatic logic [1:0] f_end_state(input logic i_wr, input logic i_hit);
    if (i_wr)       f_end_state = c_MODIFIED;
    else if (i_hit) f_end_state = c_SHARED;
    else            f_end_state = c_EXCLUSIVE;
  endfunction

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state      <= S_IDLE;
      r_gnt        <= 1'b0;
      r_last_grant <= 1'b1;
      r_write      <= 1'b0;
      r_hit        <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      done         <= 2'b00;
      resp_data    <= '0;
      resp_state   <= 2'b00;
      snoop_req    <= 2'b00;
      snoop_inv    <= 2'b00;
      snoop_addr   <= '0;
      mem_ren      <= 1'b0;
      mem_wen      <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      done <= 2'b00;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_gnt        <= w_gnt;
            r_last_grant <= w_gnt;
            r_addr       <= w_req_addr;
            r_write      <= req_write[w_gnt];
            snoop_req    <= w_other_mask;
            snoop_inv    <= req_write[w_gnt] ? w_other_mask : 2'b00;
            snoop_addr   <= w_req_addr;
            r_state      <= S_SNOOP;
          end
        end

        S_SNOOP: begin
          snoop_req  <= 2'b00;
          snoop_inv  <= 2'b00;
          snoop_addr <= '0;
          r_hit      <= w_other_hit;
          r_data     <= w_other_data;
          if (w_other_hit && w_other_dirty) begin
            mem_wen   <= 1'b1;
            mem_addr  <= r_addr;
            mem_wdata <= w_other_data;
            r_state   <= S_WB;
          end else if (w_other_hit) begin
            // Clean cache-to-cache transfer: respond straight away.
            done       <= r_gnt ? 2'b10 : 2'b01;
            resp_data  <= w_other_data;
            resp_state <= f_end_state(r_write, 1'b1);
            r_state    <= S_RESP;
          end else begin
            mem_ren  <= 1'b1;
            mem_addr <= r_addr;
            r_state  <= S_MEMRD;
          end
        end

        S_WB: begin
          if (!mem_busy) begin
            mem_wen    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            done       <= r_gnt ? 2'b10 : 2'b01;
            resp_data  <= r_data;
            resp_state <= f_end_state(r_write, r_hit);
            r_state    <= S_RESP;
          end
        end

        S_MEMRD: begin
          if (!mem_busy) begin
            mem_ren    <= 1'b0;
            mem_addr   <= '0;
            r_data     <= mem_rdata;
            done       <= r_gnt ? 2'b10 : 2'b01;
            resp_data  <= mem_rdata;
            resp_state <= f_end_state(r_write, r_hit);
            r_state    <= S_RESP;
          end
        end

        S_RESP: begin
          resp_data  <= '0;
          resp_state <= 2'b00;
          r_state    <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_coherence_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_coherence_bus_ctrl
//  Purpose  : Self-checking bench for coherence_bus_ctrl. Expected behaviour is
//             derived per transaction from the protocol rules (grant choice,
//             snoop outcome, memory latency) as a cycle-indexed timeline.
//  Revision : 1.0  initial release
// ============================================================================
module tb_coherence_bus_ctrl;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_write = 2'b00;
  logic [31:0] req_addr0 = '0;
  logic [31:0] req_addr1 = '0;
  logic [1:0]  done;
  logic [31:0] resp_data;
  logic [1:0]  resp_state;
  logic [1:0]  snoop_req;
  logic [1:0]  snoop_inv;
  logic [31:0] snoop_addr;
  logic [1:0]  snoop_hit;
  logic [1:0]  snoop_dirty;
  logic [31:0] snoop_data0;
  logic [31:0] snoop_data1;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_busy = 1'b0;

  // Per-cache line status used to answer snoops.
  logic [1:0]  cfg_hit = 2'b00;
  logic [1:0]  cfg_dirty = 2'b00;
  logic [31:0] cfg_data0 = '0;
  logic [31:0] cfg_data1 = '0;
  logic [31:0] memdata = '0;
  int          lat = 0;

  bit          model_last = 1'b1;
  int          vectors = 0;
  int          miscompares = 0;

  assign snoop_hit   = snoop_req & cfg_hit;
  assign snoop_dirty = snoop_req & cfg_dirty;
  assign snoop_data0 = cfg_data0;
  assign snoop_data1 = cfg_data1;

  always #5 CLK = ~CLK;

  coherence_bus_ctrl #(.ADDR_W(32), .WORD_W(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .done(done), .resp_data(resp_data), .resp_state(resp_state),
    .snoop_req(snoop_req), .snoop_inv(snoop_inv), .snoop_addr(snoop_addr),
    .snoop_hit(snoop_hit), .snoop_dirty(snoop_dirty),
    .snoop_data0(snoop_data0), .snoop_data1(snoop_data1),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_busy(mem_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_done"},  32'(done), 32'd0);
    chk({tag, "_rdata"}, resp_data, 32'd0);
    chk({tag, "_rstate"}, 32'(resp_state), 32'd0);
    chk({tag, "_sreq"},  32'(snoop_req), 32'd0);
    chk({tag, "_sinv"},  32'(snoop_inv), 32'd0);
    chk({tag, "_saddr"}, snoop_addr, 32'd0);
    chk({tag, "_ren"},   32'(mem_ren), 32'd0);
    chk({tag, "_wen"},   32'(mem_wen), 32'd0);
    chk({tag, "_maddr"}, mem_addr, 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk_all_zero("reset");
    nRST = 1'b1;
    model_last = 1'b1;
  endtask

  // Called in an IDLE cycle (#1 after an edge) with requests already driven.
  // Serves exactly one grant and returns in the following IDLE cycle.
  task automatic run_txn(input bit keep);
    bit          g, w, h, d, clean, win;
    logic [31:0] a, sd, ed;
    logic [1:0]  gm, om, es;
    int          rc;
    g  = (req_valid == 2'b11) ? ~model_last : req_valid[1];
    model_last = g;
    w  = req_write[g];
    a  = g ? req_addr1 : req_addr0;
    h  = cfg_hit[~g];
    d  = cfg_dirty[~g];
    sd = g ? cfg_data0 : cfg_data1;
    gm = g ? 2'b10 : 2'b01;
    om = ~gm;
    clean = h && !d;
    rc = clean ? 2 : 3 + lat;
    ed = h ? sd : memdata;
    es = w ? 2'd0 : (h ? 2'd2 : 2'd1);
    mem_busy  = 1'b0;
    mem_rdata = $urandom;
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_sreq", 32'(snoop_req), 32'd0);
    for (int k = 1; k <= rc; k++) begin
      @(posedge CLK);
      #1;
      win       = !clean && (k >= 2) && (k <= 2 + lat);
      mem_busy  = (k >= 2) && (k < 2 + lat);
      mem_rdata = (k == 2 + lat) ? memdata : $urandom;
      chk("snoop_req",  32'(snoop_req),  (k == 1) ? 32'(om) : 32'd0);
      chk("snoop_inv",  32'(snoop_inv),  (k == 1 && w) ? 32'(om) : 32'd0);
      chk("snoop_addr", snoop_addr,      (k == 1) ? a : 32'd0);
      chk("mem_wen",    32'(mem_wen),    32'(win && h));
      chk("mem_ren",    32'(mem_ren),    32'(win && !h));
      chk("mem_addr",   mem_addr,        win ? a : 32'd0);
      chk("mem_wdata",  mem_wdata,       (win && h) ? sd : 32'd0);
      chk("done",       32'(done),       (k == rc) ? 32'(gm) : 32'd0);
      chk("resp_data",  resp_data,       (k == rc) ? ed : 32'd0);
      chk("resp_state", 32'(resp_state), (k == rc) ? 32'(es) : 32'd0);
    end
    if (!keep) req_valid[g] = 1'b0;
    @(posedge CLK);
    #1;
    mem_busy = 1'b0;
  endtask

  initial begin
    do_reset();

    // Cache0 read miss, memory answers immediately.
    req_addr0 = 32'h100; req_write = 2'b00; cfg_hit = 2'b00; cfg_dirty = 2'b00;
    memdata = 32'hDEADBEEF; lat = 0; req_valid = 2'b01;
    run_txn(1'b0);

    // Cache1 read, clean hit in cache0.
    req_addr1 = 32'h200; cfg_hit = 2'b01; cfg_dirty = 2'b00; cfg_data0 = 32'h12345678;
    req_valid = 2'b10;
    run_txn(1'b0);

    // Cache0 write, dirty hit in cache1, write-back busy for 2 cycles.
    req_addr0 = 32'h300; req_write = 2'b01; cfg_hit = 2'b10; cfg_dirty = 2'b10;
    cfg_data1 = 32'hCAFEF00D; lat = 2; req_valid = 2'b01;
    run_txn(1'b0);

    // Both caches requesting continuously: grants alternate from cache0.
    do_reset();
    req_write = 2'b00; req_addr0 = 32'h400; req_addr1 = 32'h500;
    cfg_hit = 2'b00; memdata = 32'hA5A5_0001; lat = 1; req_valid = 2'b11;
    run_txn(1'b1);
    run_txn(1'b1);
    run_txn(1'b1);
    run_txn(1'b0);
    req_valid = 2'b00;

    // Reset during a busy memory read: transaction dropped, then re-served.
    req_addr1 = 32'h600; req_write = 2'b00; cfg_hit = 2'b00; req_valid = 2'b10;
    @(posedge CLK); #1;
    mem_busy = 1'b1;
    @(posedge CLK); #1;
    chk("rst_mid_ren", 32'(mem_ren), 32'd1);
    nRST = 1'b0;
    @(posedge CLK); #1;
    chk_all_zero("rst_mid");
    nRST = 1'b1;
    model_last = 1'b1;
    mem_busy = 1'b0;
    memdata = 32'h0BAD_F00D; lat = 0;
    run_txn(1'b0);

    // Long memory latency on a read miss.
    req_addr0 = 32'h700; req_write = 2'b00; cfg_hit = 2'b00;
    memdata = 32'h7777_8888; lat = 5; req_valid = 2'b01;
    run_txn(1'b0);

    // Randomized traffic; pending losers keep their address and type.
    for (int t = 0; t < 40; t++) begin
      logic [1:0] nb;
      nb = 2'($urandom_range(1, 3));
      if (!req_valid[0] && nb[0]) begin
        req_addr0 = $urandom; req_write[0] = 1'($urandom_range(0, 1));
      end
      if (!req_valid[1] && nb[1]) begin
        req_addr1 = $urandom; req_write[1] = 1'($urandom_range(0, 1));
      end
      req_valid = req_valid | nb;
      cfg_hit   = 2'($urandom);
      cfg_dirty = 2'($urandom);
      cfg_data0 = $urandom;
      cfg_data1 = $urandom;
      memdata   = $urandom;
      lat       = $urandom_range(0, 4);
      run_txn(1'b0);
    end
    req_valid = 2'b00;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
